// File: rtl/mcp3008_scan_sched.sv
// Scan sequencer and one-shot arbiter in front of the MCP3008 SPI controller.
// Define MCP3008_SCAN_AVG_EN to make bank writes average each new sample with the stored one.
module mcp3008_scan_sched #(
    parameter int SCAN_PERIOD    = 50000,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int GAP_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [7:0] chan_mask,
    input  logic       oneshot_req,
    input  logic [2:0] oneshot_chan,
    output logic       oneshot_ack,
    output logic       oneshot_done,
    output logic [9:0] oneshot_data,
    output logic       adc_start,
    output logic [2:0] adc_channel,
    input  logic [9:0] adc_data,
    input  logic       adc_valid,
    input  logic [2:0] rd_addr,
    output logic [9:0] rd_data,
    input  logic       rd_strobe,
    output logic [7:0] fresh,
    output logic       scan_done,
    output logic       timeout_err,
    input  logic       err_clr
);

    // state      | meaning
    // IDLE       | choose next conversion: one-shot, scan start, or next scan channel
    // ISSUE      | single-cycle adc_start pulse on the held channel
    // WAIT_VALID | wait for the first cycle of adc_valid, or give up on timeout
    // GAP        | let the controller go idle and release CS

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VALID, GAP} state_t;

    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          scan_pending, scan_active;
    logic [7:0]    scan_rem;
    logic [2:0]    cur_ch;
    logic          cur_os;
    logic          valid_q;
    logic [9:0]    bank [8];
    logic [9:0]    bank_wdata;

    logic       pick_os, pick_scan, start_scan;
    logic       cap_evt, tmo_evt, gap_end, scan_end;
    logic       per_tick, valid_rise;
    logic [2:0] low_ch;
    logic [7:0] fresh_set, fresh_clr;

    assign per_tick    = scan_en && (per_cnt == PER_LAST);
    assign valid_rise  = adc_valid && !valid_q;
    assign scan_end    = gap_end && !cur_os && (scan_rem == 8'd0);
    assign adc_channel = cur_ch;
    assign rd_data     = bank[rd_addr];
    assign fresh_set   = (cap_evt && !cur_os) ? (8'd1 << cur_ch) : 8'd0;
    assign fresh_clr   = rd_strobe ? (8'd1 << rd_addr) : 8'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        adc_start   = 1'b0;
        oneshot_ack = 1'b0;
        pick_os     = 1'b0;
        pick_scan   = 1'b0;
        start_scan  = 1'b0;
        cap_evt     = 1'b0;
        tmo_evt     = 1'b0;
        gap_end     = 1'b0;
        low_ch      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (scan_rem[i]) low_ch = 3'(i);
        end
        case (state)
            IDLE: begin
                if (oneshot_req) begin
                    pick_os   = 1'b1;
                    state_nxt = ISSUE;
                end else if (scan_pending) begin
                    start_scan = 1'b1;
                end else if (scan_active && scan_rem != 8'd0) begin
                    pick_scan = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                adc_start   = 1'b1;
                oneshot_ack = cur_os;
                state_nxt   = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (valid_rise) begin
                    cap_evt   = 1'b1;
                    state_nxt = GAP;
                end else if (tmo_cnt == '0) begin
                    tmo_evt   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    gap_end   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Period tick is dropped while a scan is already active or pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt      <= '0;
            scan_pending <= 1'b0;
            scan_active  <= 1'b0;
            scan_rem     <= '0;
            scan_done    <= 1'b0;
        end else begin
            if (!scan_en || per_tick) per_cnt <= '0;
            else                      per_cnt <= per_cnt + 1'b1;

            if (start_scan)                    scan_pending <= 1'b0;
            else if (per_tick && !scan_active) scan_pending <= 1'b1;

            if (start_scan) begin
                scan_active <= (chan_mask != 8'd0);
                scan_rem    <= chan_mask;
            end else begin
                if (pick_scan) scan_rem[low_ch] <= 1'b0;
                if (scan_end)  scan_active      <= 1'b0;
            end

            scan_done <= (start_scan && chan_mask == 8'd0) || scan_end;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_ch       <= '0;
            cur_os       <= 1'b0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            valid_q      <= 1'b0;
            oneshot_done <= 1'b0;
            oneshot_data <= '0;
            timeout_err  <= 1'b0;
            fresh        <= '0;
        end else begin
            valid_q <= adc_valid;

            if (pick_os) begin
                cur_ch <= oneshot_chan;
                cur_os <= 1'b1;
            end else if (pick_scan) begin
                cur_ch <= low_ch;
                cur_os <= 1'b0;
            end

            if (state == ISSUE)                          tmo_cnt <= TMO_LOAD;
            else if (state == WAIT_VALID && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

            if (cap_evt || tmo_evt)                 gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

            oneshot_done <= (cap_evt || tmo_evt) && cur_os;
            if (cap_evt && cur_os) oneshot_data <= adc_data;

            // A timeout coinciding with err_clr keeps the flag set.
            timeout_err <= tmo_evt | (timeout_err & ~err_clr);
            fresh       <= (fresh & ~fresh_clr) | fresh_set;
        end
    end

`ifdef MCP3008_SCAN_AVG_EN
    logic [7:0] primed;

    assign bank_wdata = primed[cur_ch]
        ? 10'(({1'b0, bank[cur_ch]} + {1'b0, adc_data} + 11'd1) >> 1)
        : adc_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      primed         <= '0;
        else if (cap_evt && !cur_os)   primed[cur_ch] <= 1'b1;
    end
`else
    assign bank_wdata = adc_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (cap_evt && !cur_os) begin
            bank[cur_ch] <= bank_wdata;
        end
    end

endmodule

// File: tb/tb_mcp3008_scan_sched.sv
// Bench for mcp3008_scan_sched: controller slave model, expected-conversion queue, bank model.
`timescale 1ns/1ps
module tb_mcp3008_scan_sched;
    localparam int SP   = 300;
    localparam int TO   = 40;
    localparam int GAPC = 4;
    localparam int LAT  = 3;

    typedef struct { logic [2:0] ch; logic os; } conv_t;
    typedef struct { logic [2:0] addr; logic [9:0] data; logic fr; } rd_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic       oneshot_req = 1'b0;
    logic [2:0] oneshot_chan = 3'd0;
    logic       oneshot_ack, oneshot_done;
    logic [9:0] oneshot_data;
    logic       adc_start;
    logic [2:0] adc_channel;
    logic [9:0] adc_data;
    logic       adc_valid;
    logic [2:0] rd_addr = 3'd0;
    logic [9:0] rd_data;
    logic       rd_strobe = 1'b0;
    logic [7:0] fresh;
    logic       scan_done, timeout_err;
    logic       err_clr = 1'b0;

    mcp3008_scan_sched #(.SCAN_PERIOD(SP), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .chan_mask(chan_mask),
        .oneshot_req(oneshot_req), .oneshot_chan(oneshot_chan),
        .oneshot_ack(oneshot_ack), .oneshot_done(oneshot_done), .oneshot_data(oneshot_data),
        .adc_start(adc_start), .adc_channel(adc_channel), .adc_data(adc_data),
        .adc_valid(adc_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_strobe(rd_strobe),
        .fresh(fresh), .scan_done(scan_done), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int done_cnt = 0, ack_cnt = 0, osd_cnt = 0, start_mon = 0;
    int done_cyc[$];
    int last_start_cyc = 0;
    conv_t exp_q[$];

    logic       slave_mute = 1'b0;
    logic [9:0] resp_scan = 10'h000;
    logic [9:0] resp_step = 10'h000;
    logic [9:0] mdl_bank [8];
    logic [7:0] mdl_fresh = 8'h00;
    logic [7:0] mdl_primed = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scan_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (oneshot_ack)  ack_cnt++;
        if (oneshot_done) osd_cnt++;
        if (adc_start)    start_mon++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] mdl_write(input logic [9:0] old, input logic [9:0] nw,
                                             input logic primed);
        logic [10:0] s;
        s = {1'b0, old} + {1'b0, nw} + 11'd1;
`ifdef MCP3008_SCAN_AVG_EN
        return primed ? s[10:1] : nw;
`else
        return (primed && s[0] === 1'bx) ? old : nw;
`endif
    endfunction

    // Controller slave: answers each start LAT cycles later unless muted.
    initial begin
        conv_t got, e;
        logic [9:0] d;
        adc_valid = 1'b0;
        adc_data  = 10'h000;
        forever begin
            @(posedge clk); #1;
            if (rst && adc_start) begin
                got.ch = adc_channel;
                got.os = oneshot_ack;
                last_start_cyc = cyc;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL start_unexpected: actual ch=%0d os=%0d required=no start", got.ch, got.os);
                end else begin
                    e = exp_q.pop_front();
                    if (got.ch !== e.ch || got.os !== e.os) begin
                        n_err++;
                        $display("FAIL start_order: actual ch=%0d os=%0d required ch=%0d os=%0d",
                                 got.ch, got.os, e.ch, e.os);
                    end
                end
                if (!slave_mute) begin
                    d = got.os ? 10'h150 : 10'(resp_scan + 10'(got.ch) * resp_step);
                    repeat (LAT) @(posedge clk);
                    #1;
                    adc_valid = 1'b1;
                    adc_data  = d;
                    if (rst) begin
                        chk("chan_hold", {29'd0, adc_channel}, {29'd0, got.ch});
                        if (!got.os) begin
                            mdl_bank[got.ch]   = mdl_write(mdl_bank[got.ch], d, mdl_primed[got.ch]);
                            mdl_primed[got.ch] = 1'b1;
                            mdl_fresh[got.ch]  = 1'b1;
                        end
                    end
                    @(posedge clk); #1;
                    adc_valid = 1'b0;
                end
            end
        end
    end

    task automatic check_model(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("%s_bank%0d", tag, i), {22'd0, rd_data}, {22'd0, mdl_bank[i]});
        end
        chk({tag, "_fresh"}, {24'd0, fresh}, {24'd0, mdl_fresh});
    endtask

    task automatic clear_fresh();
        for (int i = 0; i < 8; i++) begin
            rd_addr   = 3'(i);
            rd_strobe = 1'b1;
            @(posedge clk); #1;
        end
        rd_strobe = 1'b0;
        mdl_fresh = 8'h00;
    endtask

    task automatic wait_scans(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 3 * SP) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt < target) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timed out, scan_done count=%0d required=%0d", name, done_cnt, target);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) mdl_bank[i] = 10'h000;
        mdl_fresh  = 8'h00;
        mdl_primed = 8'h00;
    endtask

    initial begin
        rd_vec_t t1_vec [8];
        conv_t   c;
        int      base, n, t0;

        t1_vec = '{'{3'd0, 10'h150, 1'b1}, '{3'd1, 10'h000, 1'b0},
                   '{3'd2, 10'h150, 1'b1}, '{3'd3, 10'h000, 1'b0},
                   '{3'd4, 10'h000, 1'b0}, '{3'd5, 10'h000, 1'b0},
                   '{3'd6, 10'h000, 1'b0}, '{3'd7, 10'h000, 1'b0}};
        reset_model();

        // Reset values
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_adc_start", {31'd0, adc_start}, 0);
        chk("rst_adc_channel", {29'd0, adc_channel}, 0);
        chk("rst_ack", {31'd0, oneshot_ack}, 0);
        chk("rst_os_done", {31'd0, oneshot_done}, 0);
        chk("rst_os_data", {22'd0, oneshot_data}, 0);
        chk("rst_scan_done", {31'd0, scan_done}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        check_model("rst");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Mask 0x05 scan: ch0 then ch2
        resp_scan = 10'h150;
        resp_step = 10'h000;
        c = '{3'd0, 1'b0}; exp_q.push_back(c);
        c = '{3'd2, 1'b0}; exp_q.push_back(c);
        base = done_cnt;
        chan_mask = 8'h05;
        scan_en = 1'b1;
        wait_scans(base + 1, "t1_scan_done");
        scan_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t1_done_count", done_cnt - base, 1);
        chk("t1_queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = t1_vec[i].addr;
            #1;
            chk($sformatf("t1_bank%0d", i), {22'd0, rd_data}, {22'd0, t1_vec[i].data});
            chk($sformatf("t1_fresh%0d", i), {31'd0, fresh[t1_vec[i].addr]}, {31'd0, t1_vec[i].fr});
        end
        @(posedge clk); #1;
        rd_addr = 3'd0;
        rd_strobe = 1'b1;
        @(posedge clk); #1;
        rd_strobe = 1'b0;
        mdl_fresh[0] = 1'b0;
        chk("t1_strobe_fresh", {24'd0, fresh}, 32'h04);
        clear_fresh();

        // Full scan with one-shot ch7 inserted after ch1
        resp_scan = 10'h080;
        resp_step = 10'h011;
        c = '{3'd0, 1'b0}; exp_q.push_back(c);
        c = '{3'd1, 1'b0}; exp_q.push_back(c);
        c = '{3'd7, 1'b1}; exp_q.push_back(c);
        for (int i = 2; i < 8; i++) begin
            c = '{3'(i), 1'b0};
            exp_q.push_back(c);
        end
        base = done_cnt;
        t0 = start_mon;
        chan_mask = 8'hFF;
        scan_en = 1'b1;
        n = 0;
        while (start_mon < t0 + 2 && n < 2 * SP) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t2_reached_ch1", (start_mon >= t0 + 2), 1);
        oneshot_chan = 3'd7;
        oneshot_req = 1'b1;
        t0 = ack_cnt;
        n = 0;
        while (ack_cnt == t0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        oneshot_req = 1'b0;
        chk("t2_ack_seen", ack_cnt - t0, 1);
        t0 = osd_cnt;
        n = 0;
        while (osd_cnt == t0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t2_os_done_seen", osd_cnt - t0, 1);
        chk("t2_os_data", {22'd0, oneshot_data}, 32'h150);
        rd_addr = 3'd7;
        #1;
        chk("t2_bank7_untouched", {22'd0, rd_data}, 0);
        chk("t2_fresh7_untouched", {31'd0, fresh[7]}, 0);
        wait_scans(base + 1, "t2_scan_done");
        scan_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t2_queue_drained", exp_q.size(), 0);
        chk("t2_bank7_scan", {22'd0, mdl_bank[7]}, {22'd0, mdl_write(10'h000, 10'h0F7, 1'b0)});
        check_model("t2");
        clear_fresh();

        // Scan with a silent controller: both channels time out
        slave_mute = 1'b1;
        c = '{3'd0, 1'b0}; exp_q.push_back(c);
        c = '{3'd1, 1'b0}; exp_q.push_back(c);
        base = done_cnt;
        chan_mask = 8'h03;
        scan_en = 1'b1;
        n = 0;
        while (!timeout_err && n < 2 * SP) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_timeout_latency", cyc - last_start_cyc, TO + 1);
        wait_scans(base + 1, "t3_scan_done");
        scan_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t3_queue_drained", exp_q.size(), 0);
        chk("t3_timeout_sticky", {31'd0, timeout_err}, 1);
        check_model("t3");
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t3_err_clr", {31'd0, timeout_err}, 0);

        // One-shot timeout with err_clr landing on the timeout cycle
        c = '{3'd3, 1'b1}; exp_q.push_back(c);
        oneshot_chan = 3'd3;
        oneshot_req = 1'b1;
        n = 0;
        while (!oneshot_ack && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        oneshot_req = 1'b0;
        chk("t3b_ack", {31'd0, oneshot_ack}, 1);
        repeat (TO) @(posedge clk);
        #1;
        chk("t3b_no_early_timeout", {31'd0, timeout_err}, 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t3b_set_wins", {31'd0, timeout_err}, 1);
        chk("t3b_os_done", {31'd0, oneshot_done}, 1);
        @(posedge clk); #1;
        chk("t3b_os_done_pulse", {31'd0, oneshot_done}, 0);
        chk("t3b_os_data_kept", {22'd0, oneshot_data}, 32'h150);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t3b_err_clr", {31'd0, timeout_err}, 0);
        slave_mute = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Empty mask: scan_done every SCAN_PERIOD, never a start
        base = done_cnt;
        t0 = start_mon;
        chan_mask = 8'h00;
        scan_en = 1'b1;
        repeat (3 * SP + 10) @(posedge clk);
        #1;
        scan_en = 1'b0;
        chk("t4_done_count", done_cnt - base, 3);
        chk("t4_no_starts", start_mon - t0, 0);
        if (done_cyc.size() >= 2)
            chk("t4_done_interval", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], SP);
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of WAIT_VALID
        c = '{3'd0, 1'b0}; exp_q.push_back(c);
        t0 = start_mon;
        chan_mask = 8'hFF;
        scan_en = 1'b1;
        n = 0;
        while (start_mon == t0 && n < 2 * SP) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        scan_en = 1'b0;
        rd_addr = 3'd1;
        #1;
        chk("t5_adc_start", {31'd0, adc_start}, 0);
        chk("t5_fresh", {24'd0, fresh}, 0);
        chk("t5_bank1", {22'd0, rd_data}, 0);
        chk("t5_os_data", {22'd0, oneshot_data}, 0);
        exp_q.delete();
        reset_model();
        repeat (10) @(posedge clk);
        #1;
        check_model("t5_rst");
        rst = 1'b1;
        @(posedge clk); #1;
        resp_scan = 10'h0AB;
        resp_step = 10'h000;
        c = '{3'd0, 1'b0}; exp_q.push_back(c);
        c = '{3'd2, 1'b0}; exp_q.push_back(c);
        base = done_cnt;
        chan_mask = 8'h05;
        scan_en = 1'b1;
        wait_scans(base + 1, "t5_scan_done");
        scan_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_queue_drained", exp_q.size(), 0);
        check_model("t5");
        clear_fresh();

        // ch1 written twice: 0x100 then 0x151
        resp_scan = 10'h100;
        c = '{3'd1, 1'b0}; exp_q.push_back(c);
        base = done_cnt;
        chan_mask = 8'h02;
        scan_en = 1'b1;
        wait_scans(base + 1, "t6_scan1_done");
        scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_addr = 3'd1;
        #1;
        chk("t6_first_write", {22'd0, rd_data}, 32'h100);
        resp_scan = 10'h151;
        c = '{3'd1, 1'b0}; exp_q.push_back(c);
        base = done_cnt;
        scan_en = 1'b1;
        wait_scans(base + 1, "t6_scan2_done");
        scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_addr = 3'd1;
        #1;
`ifdef MCP3008_SCAN_AVG_EN
        chk("t6_second_write", {22'd0, rd_data}, 32'h129);
`else
        chk("t6_second_write", {22'd0, rd_data}, 32'h151);
`endif
        chk("t6_queue_drained", exp_q.size(), 0);
        check_model("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
